// File: rtl/thermometer_pkg.sv
// Shared types and width helpers for the multi-channel serial thermometer counter.
// to_bipolar() is also used by the partial-product offset logic.
package thermometer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_e;

    // Lane counter width: must hold 0..len inclusive.
    function automatic int unsigned count_width(input int unsigned len);
        return $clog2(len) + 1;
    endfunction

    // Per-channel result width: holds -len..+len in two's complement.
    function automatic int unsigned chan_width(input int unsigned len);
        return $clog2(len) + 2;
    endfunction

    // Total width: one extra bit per doubling of the lane count.
    function automatic int unsigned total_width(input int unsigned cw, input int unsigned n);
        return (n == 1) ? cw + 1 : cw + $clog2(n);
    endfunction

    function automatic int to_bipolar(input int unsigned count, input int unsigned len);
        return 2 * int'(count) - int'(len);
    endfunction

endpackage

// File: rtl/multi_channel_thermometer_counter_if.sv
// Frame handshake and result bus between the serial generators, the counter and
// the downstream adder tree.
interface multi_channel_thermometer_counter_if #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned CW           = 8,
    parameter int unsigned TW           = 10
);

    logic                       start;
    logic [NUM_CHANNELS-1:0]    serial_in;
    logic                       in_ready;
    logic                       busy;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_CHANNELS*CW-1:0] count_out;
    logic [TW-1:0]              total_out;

    modport master (
        output start,
        output serial_in,
        output out_ready,
        input  in_ready,
        input  busy,
        input  out_valid,
        input  count_out,
        input  total_out
    );

    modport slave (
        input  start,
        input  serial_in,
        input  out_ready,
        output in_ready,
        output busy,
        output out_valid,
        output count_out,
        output total_out
    );

endinterface

// File: rtl/lane_ones_counter.sv
// Counts ones on one serial lane; a load restarts the count with the bit sampled
// in the same cycle.
module lane_ones_counter #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic             serial_bit,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = WIDTH'(serial_bit);
        end else if (en) begin
            count_d = count_q + WIDTH'(serial_bit);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/multi_channel_thermometer_counter.sv
// Counts ones on N parallel serial thermometer lanes per L-bit frame and presents
// per-lane bipolar/unipolar values plus their total under a valid/ready handshake.
module multi_channel_thermometer_counter
    import thermometer_pkg::*;
#(
    parameter int unsigned SERIAL_INPUT_LENGTH = 64,
    parameter int unsigned NUM_CHANNELS        = 4,
    parameter bit          BIPOLAR             = 1'b1
) (
    input logic                               clk,
    input logic                               rst_n,
    multi_channel_thermometer_counter_if.slave bus
);

    localparam int unsigned L    = SERIAL_INPUT_LENGTH;
    localparam int unsigned N    = NUM_CHANNELS;
    localparam int unsigned CNTW = count_width(L);
    localparam int unsigned CW   = chan_width(L);
    localparam int unsigned TW   = total_width(CW, N);

    if (L < 2) begin : g_bad_length
        $error("SERIAL_INPUT_LENGTH must be at least 2");
    end
    if (N < 1) begin : g_bad_channels
        $error("NUM_CHANNELS must be at least 1");
    end

    state_e            state_q, state_d;
    logic [CNTW-1:0]   bit_cnt_q, bit_cnt_d;
    logic              in_ready;
    logic              accept;
    logic              last_bit;
    logic [CNTW-1:0]   lane_cnt [N];
    logic [CNTW-1:0]   final_cnt;
    logic [CW-1:0]     lane_val;
    logic [N*CW-1:0]   count_q, count_d;
    logic [TW-1:0]     total_q, total_d;

    // Accepting in HOLD only when the result drains keeps back-to-back frames gapless.
    assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && bus.out_ready);
    assign accept   = bus.start && in_ready;
    assign last_bit = (state_q == ACCUM) && (bit_cnt_q == CNTW'(L - 1));

    for (genvar i = 0; i < N; i++) begin : g_lane
        lane_ones_counter #(
            .WIDTH (CNTW)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (accept),
            .en         (state_q == ACCUM),
            .serial_bit (bus.serial_in[i]),
            .count      (lane_cnt[i])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = ACCUM;
            ACCUM:   if (last_bit) state_d = HOLD;
            HOLD:    if (bus.out_ready) state_d = bus.start ? ACCUM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (accept) begin
            bit_cnt_d = CNTW'(1);
        end else if (state_q == ACCUM) begin
            bit_cnt_d = bit_cnt_q + CNTW'(1);
        end
    end

    // Final counts include the last bit, which is still on serial_in this cycle.
    always_comb begin
        final_cnt = '0;
        lane_val  = '0;
        count_d   = '0;
        total_d   = '0;
        for (int i = 0; i < N; i++) begin
            final_cnt = lane_cnt[i] + CNTW'(bus.serial_in[i]);
            if (BIPOLAR) begin
                lane_val = CW'(to_bipolar(32'(final_cnt), L));
                total_d  = total_d + TW'($signed(lane_val));
            end else begin
                lane_val = CW'(final_cnt);
                total_d  = total_d + TW'(lane_val);
            end
            count_d[i*CW +: CW] = lane_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            count_q   <= '0;
            total_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            if (last_bit) begin
                count_q <= count_d;
                total_q <= total_d;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.count_out = count_q;
    assign bus.total_out = total_q;

endmodule

// File: tb/tb_multi_channel_thermometer_counter.sv
// Drives identical frames into a bipolar and a unipolar instance and scores their
// results against a popcount model.
module tb_multi_channel_thermometer_counter;

    localparam int L  = 64;
    localparam int N  = 4;
    localparam int CW = 8;
    localparam int TW = 10;

    typedef struct {
        logic [N*CW-1:0] counts;
        logic [TW-1:0]   total;
        int              due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rdy   = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q_b[$];
    exp_t q_u[$];
    bit   seen_b = 1'b0;
    bit   seen_u = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multi_channel_thermometer_counter_if #(.NUM_CHANNELS(N), .CW(CW), .TW(TW)) bus_b ();
    multi_channel_thermometer_counter_if #(.NUM_CHANNELS(N), .CW(CW), .TW(TW)) bus_u ();

    multi_channel_thermometer_counter #(
        .SERIAL_INPUT_LENGTH (L),
        .NUM_CHANNELS        (N),
        .BIPOLAR             (1'b1)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    multi_channel_thermometer_counter #(
        .SERIAL_INPUT_LENGTH (L),
        .NUM_CHANNELS        (N),
        .BIPOLAR             (1'b0)
    ) dut_u (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_u)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic exp_t model(input logic [N-1:0][L-1:0] pats, input bit bip, input int due);
        exp_t e;
        int   pc;
        int   v;
        int   tot;
        tot      = 0;
        e.counts = '0;
        for (int i = 0; i < N; i++) begin
            pc  = $countones(pats[i]);
            v   = bip ? 2 * pc - L : pc;
            e.counts[i*CW +: CW] = CW'(v);
            tot += v;
        end
        e.total = TW'(tot);
        e.due   = due;
        return e;
    endfunction

    task automatic drive(input logic st, input logic [N-1:0] s);
        bus_b.start     = st;
        bus_u.start     = st;
        bus_b.serial_in = s;
        bus_u.serial_in = s;
        bus_b.out_ready = rdy;
        bus_u.out_ready = rdy;
    endtask

    task automatic drive_frame(input logic [N-1:0][L-1:0] pats, input bit pulse_mid);
        logic [N-1:0] s;
        q_b.push_back(model(pats, 1'b1, cyc + L));
        q_u.push_back(model(pats, 1'b0, cyc + L));
        check_val("in_ready_at_start", bus_b.in_ready, 1);
        for (int j = 0; j < L; j++) begin
            for (int i = 0; i < N; i++) s[i] = pats[i][j];
            drive((j == 0) || (pulse_mid && (j == 10 || j == 40)), s);
            if (pulse_mid && j == 10) check_val("in_ready_in_accum", bus_b.in_ready, 0);
            @(posedge clk);
            #1;
            if (j == 0) check_val("busy_after_start", bus_b.busy, 1);
        end
        drive(1'b0, '0);
        check_val("busy_at_done", bus_b.busy, 0);
        check_val("valid_at_done", bus_b.out_valid, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus_b.out_valid && !seen_b) begin
            if (q_b.size() == 0) begin
                check_val("bip_unexpected_result", 1, 0);
            end else begin
                e = q_b.pop_front();
                check_val("bip_counts", bus_b.count_out, e.counts);
                check_val("bip_total", bus_b.total_out, e.total);
                check_val("bip_latency", cyc, e.due);
            end
            seen_b = 1'b1;
        end
        if (!bus_b.out_valid || bus_b.out_ready) seen_b = 1'b0;
        if (bus_u.out_valid && !seen_u) begin
            if (q_u.size() == 0) begin
                check_val("uni_unexpected_result", 1, 0);
            end else begin
                e = q_u.pop_front();
                check_val("uni_counts", bus_u.count_out, e.counts);
                check_val("uni_total", bus_u.total_out, e.total);
                check_val("uni_latency", cyc, e.due);
            end
            seen_u = 1'b1;
        end
        if (!bus_u.out_valid || bus_u.out_ready) seen_u = 1'b0;
    end

    initial begin
        logic [N-1:0][L-1:0] pats_a;
        logic [N-1:0][L-1:0] pats;
        exp_t                hold_exp;
        logic [N*CW-1:0]     hold_cnt;

        pats_a[0] = {L{1'b1}};
        pats_a[1] = '0;
        pats_a[2] = {32'h0000_0000, 32'hFFFF_FFFF};
        pats_a[3] = 64'h1;

        drive(1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_val("rst_out_valid", bus_b.out_valid, 0);
        check_val("rst_busy", bus_b.busy, 0);
        check_val("rst_in_ready", bus_b.in_ready, 1);
        check_val("rst_count_out", bus_b.count_out, 0);
        check_val("rst_total_out", bus_b.total_out, 0);
        check_val("rst_uni_count_out", bus_u.count_out, 0);

        // Reference frame: bipolar {+64,-64,0,-62}/-62, unipolar {64,0,32,1}/97.
        drive_frame(pats_a, 1'b0);

        // Back-to-back frames, lane 0 all ones then all zeros.
        pats      = {{$urandom(), $urandom()}, {$urandom(), $urandom()},
                     {$urandom(), $urandom()}, {L{1'b1}}};
        drive_frame(pats, 1'b0);
        pats[0] = '0;
        drive_frame(pats, 1'b0);

        // Extra start pulses mid-frame must be ignored.
        drive_frame(pats_a, 1'b1);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) pats[i] = {$urandom(), $urandom()};
            drive_frame(pats, 1'b0);
        end

        // Output held while downstream stalls; starts in HOLD are ignored.
        @(posedge clk);
        #1;
        rdy = 1'b0;
        drive(1'b0, '0);
        hold_exp = model(pats_a, 1'b1, 0);
        drive_frame(pats_a, 1'b0);
        hold_cnt = bus_b.count_out;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, N'($urandom()));
            check_val("hold_valid", bus_b.out_valid, 1);
            check_val("hold_in_ready", bus_b.in_ready, 0);
            check_val("hold_counts", bus_b.count_out, hold_exp.counts);
            check_val("hold_total", bus_b.total_out, hold_exp.total);
            @(posedge clk);
            #1;
        end
        rdy = 1'b1;
        drive(1'b0, '0);
        check_val("hold_valid_before_drain", bus_b.out_valid, 1);
        @(posedge clk);
        #1;
        check_val("drain_valid_low", bus_b.out_valid, 0);
        check_val("drain_busy_low", bus_b.busy, 0);
        check_val("drain_counts_kept", bus_b.count_out, hold_cnt);

        // Reset 20 cycles into a frame discards it.
        for (int j = 0; j < 20; j++) begin
            drive(j == 0, '1);
            @(posedge clk);
            #1;
        end
        drive(1'b0, '0);
        rst_n = 1'b0;
        #1;
        check_val("midrst_busy", bus_b.busy, 0);
        check_val("midrst_valid", bus_b.out_valid, 0);
        check_val("midrst_count_out", bus_b.count_out, 0);
        check_val("midrst_total_out", bus_b.total_out, 0);
        check_val("midrst_uni_count_out", bus_u.count_out, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_val("postrst_in_ready", bus_b.in_ready, 1);
        for (int i = 0; i < N; i++) pats[i] = {L{1'b1}};
        drive_frame(pats, 1'b0);

        for (int k = 0; k < 100 && (q_b.size() != 0 || q_u.size() != 0); k++) @(posedge clk);
        #1;
        check_val("scoreboard_drained", q_b.size() + q_u.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_channel_thermometer_counter.md
# multi_channel_thermometer_counter

Parametrised successor to the single-lane serial thermometer counter. It counts ones on NUM_CHANNELS parallel serial thermometer streams over a frame of SERIAL_INPUT_LENGTH bits, and converts each count to a two's-complement value (bipolar) or an unsigned value (unipolar). It also produces the cross-channel total. Output holds under a valid/ready handshake, and a new frame may start in the cycle the previous result drains. Sits between the serial partial-product generators and the partial-product adder tree.

## Interface
Parameters:
- SERIAL_INPUT_LENGTH, 64, bits per frame (L); must be ≥2.
- NUM_CHANNELS, 4, parallel serial lanes (N); must be ≥1.
- BIPOLAR, 1, 1: value = 2·count − L (signed); 0: value = count (unsigned, zero-extended).
- Derived: CW = $clog2(L)+2 (per-channel output width); TW = CW + $clog2(N) (total width; CW+1 when N=1).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame start; bit 0 of each lane is presented in the same cycle.
- serial_in  in  N  one serial bit per lane; lane i = serial_in[i].
- in_ready  out  1  start is accepted this cycle.
- busy  out  1  frame in progress (ACCUM).
- out_valid  out  1  results valid and held.
- out_ready  in  1  downstream accepts results.
- count_out  out  N·CW  lane i value at [i·CW +: CW].
- total_out  out  TW  sum of all lane values, sign-extended if BIPOLAR, else zero-extended.

## Operation
- FSM states:
  - IDLE: nothing in flight, no valid output.
  - ACCUM: counting a frame.
  - HOLD: result valid, waiting for out_ready.
- Transitions:
  - IDLE→ACCUM on start.
  - ACCUM→HOLD after L bits.
  - HOLD→IDLE on out_ready without start.
  - HOLD→ACCUM on out_ready with start.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). A start while in_ready=0 (ACCUM, or HOLD with out_ready low) is ignored and has no side effect.
- Accepted start:
  - Bit counter loads 1.
  - Each lane counter loads serial_in[i] (the start cycle is bit 0).
- ACCUM:
  - Each cycle adds serial_in[i] to lane i's counter ($clog2(L)+1 bits, range 0..L).
  - The bit counter increments.
  - When the bit counter reaches L, the counts are registered into the output stage, out_valid sets, and the state moves to HOLD.
- Output conversion is computed from the final counts when they are registered:
  - Bipolar: 2·count − L, range −L..+L in CW bits.
  - Unipolar: count in CW bits, upper bit 0.
  - total_out is the sum of the converted lane values, computed at full TW width with no overflow.
- Output registers change only on a frame completion. They are stable for the whole time out_valid=1.
- Lane counters are independent of the output registers. A new frame overwrites only the counters until it completes.

## Timing
- Reset (async assert, sync deassert expected at system level):
  - state=IDLE; all counters 0.
  - out_valid=0, busy=0, count_out=0, total_out=0.
  - in_ready=1 after reset.
- Latency: start accepted in cycle T; bits sampled in T..T+L−1; out_valid=1 from cycle T+L.
- Throughput: back-to-back frames every L cycles when out_ready is held high (start accepted in the completion-drain cycle).
- busy=1 exactly in cycles T+1..T+L−1 (ACCUM after the start cycle); busy=0 otherwise.
- Handshake: results transfer on out_valid & out_ready. out_valid stays high while out_ready is low.
- Reset asserted mid-frame or in HOLD: immediate clear. The partial frame is discarded and no output is produced.

## Structure
- Shared package thermometer_pkg:
  - state enum {IDLE, ACCUM, HOLD}.
  - Functions for CW/TW.
  - to_bipolar(count, L) conversion function, reusable by the offset logic elsewhere.
- Sub-module lane_ones_counter: one instance per lane (generate loop).
  - Inputs: clk, rst_n, load, en, bit.
  - Output: count.
- FSM, bit counter, conversion, total adder and output registers live in the top.

## Test plan
- L=64, N=4, BIPOLAR=1, out_ready=1:
  - Stimulus: lane0 all ones, lane1 all zeros, lane2 32 ones, lane3 1 one.
  - Required: out_valid at T+64; count_out lanes {+64, −64, 0, −62}; total_out=−62.
- Same stimulus with BIPOLAR=0 → lanes {64, 0, 32, 1}; total_out=97.
- out_ready=0 for 10 cycles after completion → out_valid and outputs stable, in_ready=0, extra start ignored; out_ready=1 → out_valid drops next cycle.
- Back-to-back: two frames (lane0 all ones, then all zeros) with start at T and T+64, out_ready=1 → results +64 at T+64 and −64 at T+128; no frame lost.
- start pulsed during ACCUM → ignored; result and latency identical to the single-start case.
- rst_n low at cycle T+20 of a frame → all outputs 0 immediately; in_ready=1 after release; new frame of all ones → +64.
